// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin codes and values, FSM states,
// and the largest-coin-first selection rule.
package change_dispenser_pkg;

    typedef enum logic [1:0] {
        COIN_HALF = 2'd0,
        COIN_ONE  = 2'd1,
        COIN_FIVE = 2'd2
    } coin_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    localparam int unsigned VAL_FIVE = 10;
    localparam int unsigned VAL_ONE  = 2;
    localparam int unsigned VAL_HALF = 1;

    typedef struct packed {
        logic  valid;
        coin_e coin;
    } coin_pick_t;

    function automatic int unsigned coin_value(input coin_e coin);
        case (coin)
            COIN_FIVE: return VAL_FIVE;
            COIN_ONE:  return VAL_ONE;
            default:   return VAL_HALF;
        endcase
    endfunction

    // Largest coin that fits in rem and whose tube is not empty; valid=0 if none.
    function automatic coin_pick_t pick_coin(input int unsigned rem, input logic [2:0] empty);
        coin_pick_t pick;
        pick.valid = 1'b1;
        pick.coin  = COIN_HALF;
        if (rem >= VAL_FIVE && !empty[2]) begin
            pick.coin = COIN_FIVE;
        end else if (rem >= VAL_ONE && !empty[1]) begin
            pick.coin = COIN_ONE;
        end else if (!empty[0]) begin
            pick.coin = COIN_HALF;
        end else begin
            pick.valid = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the credit logic / coin hopper side (master) and the change dispenser (slave).
interface change_dispenser_if #(
    parameter int unsigned W = 8
);
    import change_dispenser_pkg::*;

    logic         start;
    logic [W-1:0] amount;
    logic [2:0]   empty;
    logic         clr_fault;
    logic         disp_ack;
    logic         disp_req;
    coin_e        disp_type;
    logic         busy;
    logic         done;
    logic         fault;
    logic [W-1:0] remaining;

    modport master (
        output start, amount, empty, clr_fault, disp_ack,
        input  disp_req, disp_type, busy, done, fault, remaining
    );

    modport slave (
        input  start, amount, empty, clr_fault, disp_ack,
        output disp_req, disp_type, busy, done, fault, remaining
    );

endinterface

// File: rtl/change_dispenser_ack_timer.sv
// Counts cycles spent waiting for the hopper ack; expired_c flags the last allowed cycle.
module change_dispenser_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired_c
);
    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] count;

    // Fires on the ACK_TIMEOUT-th enabled cycle.
    assign expired_c = en && (count == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count <= '0;
        end else if (en && !expired_c) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Refund/change controller: pays out a credit coin by coin, largest coin first,
// over a 4-phase req/ack handshake with the coin hopper.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input  logic               CLK,
    input  logic               RST,
    change_dispenser_if.slave  bus
);

    state_e       state, next_state;
    logic [W-1:0] remaining_q, remaining_d;
    coin_e        coin_q, coin_d;
    logic         req_q, req_d;
    logic         done_q, done_d;
    logic         busy_q;
    logic         fault_q;
    coin_pick_t   pick;
    logic         ack_ok;
    logic         timer_clr;
    logic         timer_en;
    logic         expired_c;

    assign timer_clr = (state != ST_REQ);
    assign timer_en  = (state == ST_REQ) && req_q;

    change_dispenser_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (timer_clr),
        .en        (timer_en),
        .expired_c (expired_c)
    );

    // Next state, coin choice, remaining credit and registered-output intents.
    always_comb begin
        next_state  = state;
        remaining_d = remaining_q;
        coin_d      = coin_q;
        req_d       = 1'b0;
        done_d      = 1'b0;
        pick        = pick_coin(32'(remaining_q), bus.empty);
        ack_ok      = bus.disp_ack && req_q;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.amount;
                    next_state  = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    next_state = ST_DONE;
                end else if (pick.valid) begin
                    coin_d     = pick.coin;
                    next_state = ST_REQ;
                end else begin
                    next_state = ST_FAULT;
                end
            end
            ST_REQ: begin
                // First REQ cycle only raises the request; ack counts once req is visible.
                if (ack_ok) begin
                    remaining_d = remaining_q - W'(coin_value(coin_q));
                    next_state  = ST_RELEASE;
                end else if (expired_c) begin
                    next_state = ST_FAULT;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!bus.disp_ack) begin
                    next_state = ST_SELECT;
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                next_state = ST_IDLE;
            end
            ST_FAULT: begin
                if (bus.clr_fault) begin
                    remaining_d = '0;
                    next_state  = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            remaining_q <= '0;
            coin_q      <= COIN_HALF;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= next_state;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            req_q       <= req_d;
            done_q      <= done_d;
            busy_q      <= (next_state inside {ST_SELECT, ST_REQ, ST_RELEASE, ST_DONE});
            fault_q     <= (next_state == ST_FAULT);
        end
    end

    assign bus.disp_req  = req_q;
    assign bus.disp_type = coin_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a handshake-level reference model is compared
// against every output each cycle, plus hand-computed coin sequences for fixed cases.
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned TMO = 16;
    localparam int P_IDLE   = 0;
    localparam int P_ACTIVE = 1;
    localparam int P_FAULT  = 2;

    logic CLK = 1'b0;
    logic RST;

    change_dispenser_if #(.W(W)) bus ();

    change_dispenser #(
        .W           (W),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Coin value in half-yuan units <-> disp_type code.
    function automatic int pick_val(input int rem, input logic [2:0] emp);
        int vals [3];
        vals = '{10, 2, 1};
        for (int i = 0; i < 3; i++) begin
            if (rem >= vals[i] && !emp[2-i]) return vals[i];
        end
        return 0;
    endfunction

    function automatic int val_code(input int v);
        return (v == 10) ? 2 : (v == 2) ? 1 : 0;
    endfunction

    function automatic int code_val(input int c);
        return (c == 2) ? 10 : (c == 1) ? 2 : 1;
    endfunction

    // Reference model state
    int m_rem, m_phase, req_cnt, exp_type, m_start_cyc;
    bit decide_pend, req_setup, wait_low, done_pend, exp_req, exp_done;
    bit armed = 0;
    int cyc_now = 0;

    // Hopper / stimulus state
    logic [2:0] empty_cfg;
    bit noack, glitch_en, glitch;
    logic [2:0] glitch_val;
    int dly = 0;

    // Observation bookkeeping
    int coin_log [$];
    int done_cnt, first_req_cyc, req_run, last_run;
    bit prev_req = 0;

    // Model advances on the same edge as the DUT, from the input values just before it.
    always @(posedge CLK) begin
        int v;
        cyc_now++;
        if (RST) begin
            m_rem = 0; m_phase = P_IDLE; req_cnt = 0; exp_type = 0;
            decide_pend = 0; req_setup = 0; wait_low = 0; done_pend = 0;
            exp_req = 0; exp_done = 0; armed = 1;
        end else begin
            exp_done = 0;
            case (m_phase)
                P_IDLE: begin
                    if (bus.start) begin
                        m_rem = int'(bus.amount);
                        m_phase = P_ACTIVE;
                        decide_pend = 1;
                        m_start_cyc = cyc_now;
                    end
                end
                P_ACTIVE: begin
                    if (done_pend) begin
                        done_pend = 0; exp_done = 1; m_phase = P_IDLE;
                    end else if (decide_pend) begin
                        decide_pend = 0;
                        if (m_rem == 0) begin
                            done_pend = 1;
                        end else begin
                            v = pick_val(m_rem, bus.empty);
                            if (v == 0) m_phase = P_FAULT;
                            else begin
                                exp_type = val_code(v);
                                req_setup = 1;
                            end
                        end
                    end else if (req_setup) begin
                        req_setup = 0; exp_req = 1; req_cnt = 0;
                    end else if (exp_req) begin
                        if (bus.disp_ack) begin
                            m_rem -= code_val(exp_type);
                            exp_req = 0; wait_low = 1;
                        end else begin
                            req_cnt++;
                            if (req_cnt == int'(TMO)) begin
                                exp_req = 0; m_phase = P_FAULT;
                            end
                        end
                    end else if (wait_low && !bus.disp_ack) begin
                        wait_low = 0; decide_pend = 1;
                    end
                end
                default: begin
                    if (bus.clr_fault) begin
                        m_phase = P_IDLE; m_rem = 0;
                    end
                end
            endcase
        end
    end

    // Hopper: acks each request after a random delay, drops ack after req falls.
    always @(negedge CLK) begin
        if (RST) begin
            bus.disp_ack = 1'b0; dly = 0; glitch = 0;
        end else if (!bus.disp_ack) begin
            if (bus.disp_req && !noack) begin
                if (dly == 0) begin
                    bus.disp_ack = 1'b1; glitch = 0; dly = int'($urandom_range(0, 3));
                end else begin
                    dly--;
                    if (glitch_en && $urandom_range(0, 1) == 1) begin
                        glitch = 1; glitch_val = 3'($urandom);
                    end
                end
            end
        end else if (!bus.disp_req) begin
            if (dly == 0) begin
                bus.disp_ack = 1'b0; dly = int'($urandom_range(0, 3));
            end else begin
                dly--;
            end
        end
        bus.empty = glitch ? glitch_val : empty_cfg;
    end

    // Per-cycle compare against the model.
    always @(negedge CLK) begin
        if (armed) begin
            chk("remaining", int'(bus.remaining), m_rem);
            chk("disp_req", int'(bus.disp_req), int'(exp_req));
            chk("disp_type", int'(bus.disp_type), exp_type);
            chk("busy", int'(bus.busy), int'(m_phase == P_ACTIVE));
            chk("done", int'(bus.done), int'(exp_done));
            chk("fault", int'(bus.fault), int'(m_phase == P_FAULT));
            if (bus.disp_req && !prev_req) begin
                coin_log.push_back(int'(bus.disp_type));
                if (first_req_cyc < 0) first_req_cyc = cyc_now;
            end
            if (bus.disp_req) req_run++;
            else if (req_run > 0) begin
                last_run = req_run; req_run = 0;
            end
            if (bus.done) done_cnt++;
            prev_req = bus.disp_req;
        end
    end

    task automatic run_txn(input int amt, input logic [2:0] emp, input bit noise);
        int cyc;
        coin_log.delete(); done_cnt = 0; first_req_cyc = -1;
        empty_cfg = emp;
        bus.amount = W'(amt);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        cyc = 0;
        while (m_phase == P_ACTIVE && cyc < 3000) begin
            bus.start  = noise && ($urandom_range(0, 7) == 0);
            bus.amount = W'($urandom_range(0, 255));
            @(negedge CLK);
            cyc++;
        end
        bus.start = 1'b0;
        chk("txn_finished", int'(cyc < 3000), 1);
        @(negedge CLK);
    endtask

    task automatic clear_fault();
        bus.clr_fault = 1'b1;
        @(negedge CLK);
        bus.clr_fault = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp1 [5];
        int w;
        exp1 = '{2, 1, 1, 1, 0};
        RST = 1'b1; bus.start = 1'b0; bus.amount = '0; bus.clr_fault = 1'b0;
        empty_cfg = 3'b000; noack = 0; glitch_en = 0;
        req_run = 0; last_run = 0; done_cnt = 0; first_req_cyc = -1;
        repeat (3) @(negedge CLK);
        chk("rst_remaining", int'(bus.remaining), 0);
        chk("rst_disp_req", int'(bus.disp_req), 0);
        chk("rst_disp_type", int'(bus.disp_type), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_fault", int'(bus.fault), 0);
        RST = 1'b0;
        @(negedge CLK);

        // 8.5 yuan, all tubes full: 5, 1, 1, 1, 0.5
        run_txn(17, 3'b000, 0);
        chk("t1_coin_count", coin_log.size(), 5);
        for (int i = 0; i < 5 && i < coin_log.size(); i++)
            chk($sformatf("t1_coin%0d", i), coin_log[i], exp1[i]);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_req_latency", first_req_cyc - m_start_cyc, 2);
        chk("t1_remaining", int'(bus.remaining), 0);

        // 6 yuan, 5-yuan tube empty: six 1-yuan coins
        run_txn(12, 3'b100, 0);
        chk("t2_coin_count", coin_log.size(), 6);
        foreach (coin_log[i]) chk($sformatf("t2_coin%0d", i), coin_log[i], 1);
        chk("t2_done_pulses", done_cnt, 1);

        // 1.5 yuan, half tube empty: one 1-yuan coin then fault with 1 owed
        run_txn(3, 3'b001, 0);
        chk("t3_coin_count", coin_log.size(), 1);
        if (coin_log.size() > 0) chk("t3_coin0", coin_log[0], 1);
        chk("t3_fault", int'(bus.fault), 1);
        chk("t3_remaining", int'(bus.remaining), 1);
        chk("t3_done_pulses", done_cnt, 0);
        clear_fault();
        chk("t3_cleared_fault", int'(bus.fault), 0);
        chk("t3_cleared_remaining", int'(bus.remaining), 0);

        // Hopper never acks: request held exactly TMO cycles, then fault with nothing paid
        noack = 1;
        run_txn(25, 3'b000, 0);
        chk("t4_req_cycles", last_run, 16);
        chk("t4_fault", int'(bus.fault), 1);
        chk("t4_remaining", int'(bus.remaining), 25);
        chk("t4_disp_req", int'(bus.disp_req), 0);
        noack = 0;
        clear_fault();

        // Reset while a request is outstanding
        noack = 1;
        empty_cfg = 3'b000;
        bus.amount = W'(40);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        w = 0;
        while (!bus.disp_req && w < 10) begin
            @(negedge CLK);
            w++;
        end
        chk("t5_req_seen", int'(bus.disp_req), 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_disp_req", int'(bus.disp_req), 0);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_remaining", int'(bus.remaining), 0);
        RST = 1'b0;
        noack = 0;
        @(negedge CLK);
        run_txn(9, 3'b000, 0);
        chk("t5_after_coins", coin_log.size(), 5);
        chk("t5_after_done", done_cnt, 1);

        // Zero credit: done two edges after start, no request; start while busy ignored
        coin_log.delete(); done_cnt = 0;
        bus.amount = W'(0);
        bus.start = 1'b1;
        @(negedge CLK);
        chk("t6_busy", int'(bus.busy), 1);
        bus.amount = W'(50);
        @(negedge CLK);
        bus.start = 1'b0;
        chk("t6_done_early", int'(bus.done), 0);
        @(negedge CLK);
        chk("t6_done", int'(bus.done), 1);
        @(negedge CLK);
        chk("t6_idle", int'(bus.busy), 0);
        chk("t6_no_req", coin_log.size(), 0);
        chk("t6_remaining", int'(bus.remaining), 0);

        // Random transactions with ignored starts, tube glitches mid-request and timeouts
        glitch_en = 1;
        for (int t = 0; t < 40; t++) begin
            logic [2:0] emp;
            emp = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            noack = ($urandom_range(0, 9) == 0);
            run_txn(int'($urandom_range(0, 80)), emp, 1);
            noack = 0;
            if (m_phase == P_FAULT) clear_fault();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
